// File: rtl/spi_txn_scheduler_if.sv
// Bundle between the SPI transaction scheduler and its neighbours: command push,
// response pop, SPI master control, status, and an FSM debug view.
interface spi_txn_scheduler_if;
    // tx_* and rsp_* are valid/ready channels: a byte moves on a clk edge with valid && ready
    // both high, and once valid is raised it stays high with data stable until accepted.
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic       err_timeout;
    logic       busy;
    logic       m_newd;
    logic [7:0] m_din;
    logic       m_cs;
    logic [7:0] m_dout;
    logic [1:0] dbg_state;

    modport slave (
        input  tx_valid, tx_data, rsp_ready, m_cs, m_dout,
        output tx_ready, rsp_valid, rsp_data, err_timeout, busy, m_newd, m_din, dbg_state
    );

    modport master (
        output tx_valid, tx_data, rsp_ready, m_cs, m_dout,
        input  tx_ready, rsp_valid, rsp_data, err_timeout, busy, m_newd, m_din, dbg_state
    );
endinterface

// File: rtl/spi_txn_scheduler.sv
// Queues command bytes and runs one SPI master transaction per byte, returning the
// byte shifted back by the chain; transactions that never start or never end are flagged.
module spi_txn_scheduler #(
    parameter int DEPTH        = 4,
    parameter int REQ_TIMEOUT  = 64,
    parameter int XFER_TIMEOUT = 512
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_txn_scheduler_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (XFER_TIMEOUT > REQ_TIMEOUT) ? XFER_TIMEOUT : REQ_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] REQ_LAST  = TW'(REQ_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LAST = TW'(XFER_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          cs_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    acc_q;
    logic          newd_q;
    logic [7:0]    din_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic          err_q;

    logic push, pop, timer_clr, timeout, capture;
    logic fifo_empty, fifo_full;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign push       = bus.tx_valid && !fifo_full;

    // ---------------- command FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        timer_clr = 1'b0;
        timeout   = 1'b0;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Launch only once the master has released cs from any earlier transfer.
                if (!fifo_empty && cs_q) begin
                    pop       = 1'b1;
                    timer_clr = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (!cs_q) begin
                    timer_clr = 1'b1;
                    state_d   = S_XFER;
                end else if (timer_q == REQ_LAST) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (cs_q) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (timer_q == XFER_LAST) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q        <= 1'b1;
            timer_q     <= '0;
            acc_q       <= '0;
            newd_q      <= 1'b0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            cs_q <= bus.m_cs;

            if (timer_clr || !(state_q == S_REQ || state_q == S_XFER)) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end

            // m_dout is zero outside the result window, so OR-ing every XFER cycle yields the byte.
            if (pop) begin
                acc_q <= '0;
            end else if (state_q == S_XFER) begin
                acc_q <= acc_q | bus.m_dout;
            end

            if (pop) begin
                din_q <= mem[rd_ptr_q];
            end

            // newd trails the REQ state by one cycle, so it stays up for the cycle after cs is seen low.
            newd_q <= (state_q == S_REQ);

            if (capture) begin
                rsp_data_q <= acc_q;
            end
            rsp_valid_q <= (state_d == S_DONE);
            err_q       <= timeout;
        end
    end

    assign bus.tx_ready    = !fifo_full;
    assign bus.busy        = (state_q != S_IDLE) || !fifo_empty;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.err_timeout = err_q;
    assign bus.m_newd      = newd_q;
    assign bus.m_din       = din_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Bench for spi_txn_scheduler: a behavioural SPI master/chain answers each launch,
// and a response scoreboard checks returned bytes in order.
module tb_spi_txn_scheduler;
    logic clk;
    logic rst_n;
    int   cyc = 0;

    spi_txn_scheduler_if bus ();

    spi_txn_scheduler #(
        .DEPTH(4),
        .REQ_TIMEOUT(64),
        .XFER_TIMEOUT(512)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] cmd_q[$];

    int master_mode = 0;  // 0: normal transfer, 1: never drop cs, 2: hold cs low 600 cycles
    int model_busy  = 0;
    int cs_fall     = 0;
    int cs_rise     = 0;
    int err_cnt     = 0;
    int rsp_cnt     = 0;

    // ---------------- clock/reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] resp_map(input logic [7:0] d);
        case (d)
            8'hA5:   return 8'h3C;
            8'h0F:   return 8'h00;
            default: return {d[3:0], d[7:4]} ^ 8'h96;
        endcase
    endfunction

    // ---------------- SPI master + slave chain model ----------------
    initial begin
        logic [7:0] d;
        logic [7:0] r;
        bus.m_cs   = 1'b1;
        bus.m_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.m_newd === 1'b1 && master_mode != 1) begin
                model_busy = 1;
                if (master_mode == 0) begin
                    n_checks++;
                    if (cmd_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL launch_unexpected: got m_din=%0h with no command queued", bus.m_din);
                        r = 8'h00;
                    end else begin
                        d = cmd_q.pop_front();
                        if (bus.m_din !== d) begin
                            n_fail++;
                            $display("FAIL launch_din: got %0h expected %0h", bus.m_din, d);
                        end
                        r = resp_map(d);
                    end
                    repeat ($urandom_range(3, 8)) @(posedge clk);
                    #1;
                    n_checks++;
                    if (bus.m_newd !== 1'b1) begin
                        n_fail++;
                        $display("FAIL newd_hold: got %0b expected 1", bus.m_newd);
                    end
                    bus.m_cs = 1'b0;
                    cs_fall  = cyc;
                    repeat (56) @(posedge clk);
                    #1 bus.m_dout = r;
                    repeat (8) @(posedge clk);
                    #1;
                    bus.m_cs   = 1'b1;
                    bus.m_dout = 8'h00;
                    cs_rise    = cyc;
                end else begin
                    bus.m_cs = 1'b0;
                    cs_fall  = cyc;
                    repeat (600) @(posedge clk);
                    #1 bus.m_cs = 1'b1;
                end
                repeat (2) @(posedge clk);
                model_busy = 0;
            end
        end
    end

    // ---------------- scoreboard / monitors ----------------
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.err_timeout === 1'b1) err_cnt++;
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                rsp_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %0h expected no response", bus.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rsp_data !== e) begin
                        n_fail++;
                        $display("FAIL rsp_data: got %0h expected %0h", bus.rsp_data, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a clock edge; returns #1 after the edge that accepted the byte.
    task automatic push_byte(input logic [7:0] d, input bit expect_rsp, output int waited);
        waited = 0;
        while (bus.tx_ready !== 1'b1 && waited < 1000) begin
            @(posedge clk);
            #1 waited++;
        end
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        if (expect_rsp) begin
            exp_q.push_back(resp_map(d));
            cmd_q.push_back(d);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_model_idle(output bit ok);
        int w = 0;
        while (model_busy != 0 && w < 1000) begin
            @(posedge clk);
            #1 w++;
        end
        ok = (model_busy == 0);
    endtask

    task automatic wait_exp_empty(input int budget, output bit ok);
        int w = 0;
        while (exp_q.size() != 0 && w < budget) begin
            @(posedge clk);
            #1 w++;
        end
        ok = (exp_q.size() == 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        n_checks += 7;
        if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %0b expected 1", bus.tx_ready); end
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid); end
        if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %0h expected 0", bus.rsp_data); end
        if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", bus.err_timeout); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        if (bus.m_newd !== 1'b0 || bus.m_din !== 8'h00) begin
            n_fail++; $display("FAIL reset_master: got newd=%0b din=%0h expected 0/00", bus.m_newd, bus.m_din);
        end
        if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
    endtask

    task automatic test_single_byte;
        int  w;
        int  e0;
        int  held_bad;
        bit  ok;
        bus.rsp_ready = 1'b0;
        e0 = err_cnt;
        push_byte(8'hA5, 1'b1, w);
        n_checks += 4;
        if (bus.m_newd !== 1'b0) begin n_fail++; $display("FAIL single_newd_n: got %0b expected 0", bus.m_newd); end
        wait_cycles(1);
        if (bus.m_newd !== 1'b0) begin n_fail++; $display("FAIL single_newd_n1: got %0b expected 0", bus.m_newd); end
        if (bus.m_din !== 8'hA5) begin n_fail++; $display("FAIL single_din: got %0h expected a5", bus.m_din); end
        wait_cycles(1);
        if (bus.m_newd !== 1'b1) begin n_fail++; $display("FAIL single_newd_n2: got %0b expected 1", bus.m_newd); end
        w = 0;
        while (bus.rsp_valid !== 1'b1 && w < 300) begin
            @(posedge clk);
            #1 w++;
        end
        n_checks += 3;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_rsp_timeout: got no rsp_valid expected within 300 cycles");
        end
        if (cyc - cs_rise !== 2) begin n_fail++; $display("FAIL single_rsp_latency: got %0d expected 2", cyc - cs_rise); end
        if (bus.rsp_data !== 8'h3C) begin n_fail++; $display("FAIL single_rsp_data: got %0h expected 3c", bus.rsp_data); end
        held_bad = 0;
        repeat (5) begin
            wait_cycles(1);
            if (bus.rsp_valid !== 1'b1) held_bad++;
        end
        n_checks++;
        if (held_bad != 0) begin n_fail++; $display("FAIL single_rsp_hold: got %0d drops expected 0", held_bad); end
        bus.rsp_ready = 1'b1;
        wait_cycles(1);
        wait_model_idle(ok);
        n_checks += 3;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_clear: got %0b expected 0", bus.rsp_valid); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_consumed: got %0d pending expected 0", exp_q.size()); end
        if (err_cnt != e0 || !ok) begin n_fail++; $display("FAIL single_err: got %0d errors expected 0", err_cnt - e0); end
        wait_cycles(4);
    endtask

    task automatic test_zero_response;
        int w;
        int e0;
        bit ok;
        e0 = err_cnt;
        bus.rsp_ready = 1'b1;
        wait_cycles($urandom_range(1, 4));
        push_byte(8'h0F, 1'b1, w);
        wait_exp_empty(300, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL zero_rsp: got %0d pending expected 0", exp_q.size()); end
        if (err_cnt != e0) begin n_fail++; $display("FAIL zero_err: got %0d errors expected 0", err_cnt - e0); end
        wait_model_idle(ok);
        wait_cycles(4);
    endtask

    task automatic test_fifo_fill;
        int w;
        int r0;
        bit ok;
        bus.rsp_ready = 1'b1;
        r0 = rsp_cnt;
        for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b1, w);
        n_checks += 2;
        if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL fill_tx_ready: got %0b expected 0", bus.tx_ready); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %0b expected 1", bus.busy); end
        push_byte(8'h06, 1'b1, w);
        n_checks++;
        if (w == 0) begin n_fail++; $display("FAIL fill_holdoff: got %0d wait cycles expected >0", w); end
        wait_exp_empty(1500, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL fill_drain: got %0d pending expected 0", exp_q.size()); end
        if (rsp_cnt - r0 != 6) begin n_fail++; $display("FAIL fill_count: got %0d responses expected 6", rsp_cnt - r0); end
        wait_model_idle(ok);
        wait_cycles(3);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fill_idle_busy: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_backpressure;
        int w;
        int newd_bad;
        bit ok;
        bus.rsp_ready = 1'b0;
        push_byte(8'h11, 1'b1, w);
        push_byte(8'h22, 1'b1, w);
        w = 0;
        while (bus.rsp_valid !== 1'b1 && w < 300) begin
            @(posedge clk);
            #1 w++;
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got no rsp_valid expected within 300 cycles"); end
        newd_bad = 0;
        repeat (100) begin
            wait_cycles(1);
            if (bus.m_newd !== 1'b0) newd_bad++;
        end
        n_checks += 3;
        if (newd_bad != 0) begin n_fail++; $display("FAIL bp_newd: got %0d cycles high expected 0", newd_bad); end
        if (bus.dbg_state !== 2'd3) begin n_fail++; $display("FAIL bp_state: got %0d expected 3", bus.dbg_state); end
        if (exp_q.size() != 2) begin n_fail++; $display("FAIL bp_pending: got %0d expected 2", exp_q.size()); end
        bus.rsp_ready = 1'b1;
        wait_exp_empty(400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size()); end
        wait_model_idle(ok);
        wait_cycles(4);
    endtask

    task automatic test_req_timeout;
        int w;
        int t0;
        int e0;
        int r0;
        bit ok;
        master_mode   = 1;
        bus.rsp_ready = 1'b1;
        e0 = err_cnt;
        r0 = rsp_cnt;
        push_byte(8'h77, 1'b0, w);
        t0 = cyc;
        w = 0;
        while (bus.err_timeout !== 1'b1 && w < 200) begin
            @(posedge clk);
            #1 w++;
        end
        n_checks += 2;
        if (bus.err_timeout !== 1'b1) begin n_fail++; $display("FAIL req_to_seen: got no err_timeout expected one"); end
        if (cyc - t0 != 65) begin n_fail++; $display("FAIL req_to_time: got %0d expected 65", cyc - t0); end
        wait_cycles(1);
        n_checks += 2;
        if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL req_to_pulse: got %0b expected 0", bus.err_timeout); end
        if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL req_to_state: got %0d expected 0", bus.dbg_state); end
        wait_cycles(4);
        n_checks += 2;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL req_to_busy: got %0b expected 0", bus.busy); end
        if (err_cnt - e0 != 1 || rsp_cnt != r0) begin
            n_fail++; $display("FAIL req_to_count: got err=%0d rsp=%0d expected 1/0", err_cnt - e0, rsp_cnt - r0);
        end
        master_mode = 0;
        wait_model_idle(ok);
    endtask

    task automatic test_xfer_timeout;
        int w;
        int r0;
        bit ok;
        master_mode   = 2;
        bus.rsp_ready = 1'b1;
        r0 = rsp_cnt;
        push_byte(8'h66, 1'b0, w);
        w = 0;
        while (bus.err_timeout !== 1'b1 && w < 700) begin
            @(posedge clk);
            #1 w++;
        end
        n_checks += 3;
        if (bus.err_timeout !== 1'b1) begin n_fail++; $display("FAIL xfer_to_seen: got no err_timeout expected one"); end
        if (cyc - cs_fall != 514) begin n_fail++; $display("FAIL xfer_to_time: got %0d expected 514", cyc - cs_fall); end
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL xfer_to_rsp: got %0b expected 0", bus.rsp_valid); end
        wait_model_idle(ok);
        wait_cycles(4);
        n_checks++;
        if (rsp_cnt != r0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL xfer_to_idle: got rsp=%0d busy=%0b expected 0/0", rsp_cnt - r0, bus.busy);
        end
        master_mode = 0;
    endtask

    task automatic test_reset_mid_xfer;
        int w;
        bit ok;
        bus.rsp_ready = 1'b1;
        push_byte(8'h33, 1'b1, w);
        push_byte(8'h44, 1'b1, w);
        w = 0;
        while (bus.dbg_state !== 2'd2 && w < 100) begin
            @(posedge clk);
            #1 w++;
        end
        n_checks++;
        if (bus.dbg_state !== 2'd2) begin n_fail++; $display("FAIL rst_mid_xfer: got state %0d expected 2", bus.dbg_state); end
        #2 rst_n = 1'b0;
        exp_q.delete();
        cmd_q.delete();
        #1;
        n_checks += 3;
        if (bus.m_newd !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_out: got newd=%0b rv=%0b err=%0b expected 0/0/0", bus.m_newd, bus.rsp_valid, bus.err_timeout);
        end
        if (bus.busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_async_fifo: got busy=%0b tx_ready=%0b expected 0/1", bus.busy, bus.tx_ready);
        end
        if (bus.m_din !== 8'h00 || bus.dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rst_async_state: got din=%0h state=%0d expected 00/0", bus.m_din, bus.dbg_state);
        end
        wait_model_idle(ok);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(6);
        n_checks += 2;
        if (bus.busy !== 1'b0 || bus.dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rst_after_idle: got busy=%0b state=%0d expected 0/0", bus.busy, bus.dbg_state);
        end
        if (bus.m_newd !== 1'b0 || bus.rsp_valid !== 1'b0 || !ok) begin
            n_fail++; $display("FAIL rst_after_quiet: got newd=%0b rv=%0b expected 0/0", bus.m_newd, bus.rsp_valid);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n         = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        wait_cycles(2);
        test_single_byte();
        test_zero_response();
        test_fifo_fill();
        test_backpressure();
        test_req_timeout();
        test_xfer_timeout();
        test_reset_mid_xfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
